// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: the VDP owns the single-port RAM whenever vdp_slot is high; one aux port is served in free slots via req/ack.
// Optional feature macro VRAM_ARB_AUX_WRITE_EN: when undefined, every aux access is a read and ram_we comes only from the VDP.
module vram_slot_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_w,
  input  logic              rst_n_w,
  input  logic              vdp_slot,
  input  logic              vdp_we_n,
  input  logic [ADDR_W-1:0] vdp_adr,
  input  logic [7:0]        vdp_dbo,
  output logic [7:0]        vdp_dbi,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_adr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        aux_rdata,
  output logic              aux_busy,
  output logic              aux_starve,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                accept_s, issue_s;
  logic                lat_wr_r;
  logic [ADDR_W-1:0]   lat_adr_r;
  logic [7:0]          lat_wdata_r;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic                prev_aux_r;
  logic [7:0]          vdp_hold_r;
  logic                aux_ack_r;
  logic [7:0]          aux_rdata_r;

  // Next-state decode; the issue cycle is WAIT with the slot free.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (aux_req) begin
          accept_s    = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!vdp_slot) begin
          issue_s     = 1'b1;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DATA:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, starvation counter and aux response registers.
  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      lat_wr_r     <= 1'b0;
      lat_adr_r    <= '0;
      lat_wdata_r  <= 8'h00;
      starve_cnt_r <= '0;
      aux_ack_r    <= 1'b0;
      aux_rdata_r  <= 8'h00;
    end else begin
      if (accept_s) begin
`ifdef VRAM_ARB_AUX_WRITE_EN
        lat_wr_r    <= aux_wr;
`else
        lat_wr_r    <= 1'b0;
`endif
        lat_adr_r   <= aux_adr;
        lat_wdata_r <= aux_wdata;
      end
      if (accept_s) begin
        starve_cnt_r <= '0;
      end else if (state_r == WAIT && vdp_slot && starve_cnt_r != CNT_W'(STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
      aux_ack_r <= (state_r == DATA);
      if (state_r == DATA) begin
        aux_rdata_r <= ram_dout;
      end
    end
  end

`ifndef VRAM_ARB_AUX_WRITE_EN
  logic unused_aux_wr_s;
  assign unused_aux_wr_s = aux_wr;
`endif

  // Hold the VDP's last read data across the cycle in which ram_dout carries aux data.
  always_ff @(posedge clk_w or negedge rst_n_w) begin
    if (!rst_n_w) begin
      prev_aux_r <= 1'b0;
      vdp_hold_r <= 8'h00;
    end else begin
      prev_aux_r <= issue_s;
      if (!prev_aux_r) begin
        vdp_hold_r <= ram_dout;
      end
    end
  end

  // RAM port mux: the VDP slot always wins, aux only drives the RAM in its issue cycle.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = vdp_adr;
    ram_din  = vdp_dbo;
    if (vdp_slot) begin
      ram_we   = ~vdp_we_n;
    end else if (issue_s) begin
      ram_we   = lat_wr_r;
      ram_addr = lat_adr_r;
      ram_din  = lat_wdata_r;
    end else begin
      ram_we   = 1'b0;
    end
  end

  assign vdp_dbi    = prev_aux_r ? vdp_hold_r : ram_dout;
  assign aux_ack    = aux_ack_r;
  assign aux_rdata  = aux_rdata_r;
  assign aux_busy   = (state_r != IDLE);
  assign aux_starve = (starve_cnt_r == CNT_W'(STARVE_MAX));

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter: a behavioural RAM plus a transaction-level model
// (shadow memory, latency = 2 + busy slot cycles) under randomized slot patterns and requests.
module tb_vram_slot_arbiter;

  localparam int ADDR_W = 15;
  localparam int SMAX   = 4;
`ifdef VRAM_ARB_AUX_WRITE_EN
  localparam bit AUX_WE = 1'b1;
`else
  localparam bit AUX_WE = 1'b0;
`endif

  logic              clk_w = 1'b0;
  logic              rst_n_w;
  logic              vdp_slot, vdp_we_n;
  logic [ADDR_W-1:0] vdp_adr;
  logic [7:0]        vdp_dbo, vdp_dbi;
  logic              aux_req, aux_wr, aux_ack, aux_busy, aux_starve;
  logic [ADDR_W-1:0] aux_adr;
  logic [7:0]        aux_wdata, aux_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din, ram_dout;

  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = 8'h00;
  logic [7:0]        mem     [0:32767];
  logic [7:0]        ref_mem [0:32767];

  int checks = 0;
  int errors = 0;

  vram_slot_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
    .clk_w(clk_w), .rst_n_w(rst_n_w),
    .vdp_slot(vdp_slot), .vdp_we_n(vdp_we_n), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_dbi(vdp_dbi),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_adr(aux_adr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_busy(aux_busy), .aux_starve(aux_starve),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk_w = ~clk_w;

  // Registered single-port RAM, read-first, with a backdoor load path.
  always @(posedge clk_w) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // One aux transaction with `busy` slot-high cycles in WAIT; VDP reads vaddr during those cycles.
  task automatic run_aux(input logic wr, input logic [ADDR_W-1:0] adr, input logic [7:0] wd,
                         input int busy, input logic [ADDR_W-1:0] vaddr);
    logic [7:0] exp_rd;
    logic       exp_we;
    exp_rd = ref_mem[adr];
    exp_we = AUX_WE & wr;
    aux_req = 1'b1; aux_wr = wr; aux_adr = adr; aux_wdata = wd;
    vdp_slot = 1'b0; vdp_we_n = 1'b1;
    tick();
    // Garbage on the request lines must be ignored until the ack cycle.
    aux_req = 1'($urandom_range(0, 1)); aux_wr = ~wr;
    aux_adr = ADDR_W'($urandom); aux_wdata = 8'($urandom);
    for (int i = 0; i < busy; i++) begin
      vdp_slot = 1'b1; vdp_adr = vaddr;
      #1;
      checks++; if (ram_we !== 1'b0 || ram_addr !== vaddr) begin errors++;
        $display("FAIL slot_owner: we=%b addr=%h want we=0 addr=%h", ram_we, ram_addr, vaddr); end
      checks++; if (aux_busy !== 1'b1 || aux_ack !== 1'b0) begin errors++;
        $display("FAIL wait_state: busy=%b ack=%b want 1/0", aux_busy, aux_ack); end
      checks++; if (aux_starve !== (i >= SMAX)) begin errors++;
        $display("FAIL starve_wait: got %b want %b (i=%0d)", aux_starve, (i >= SMAX), i); end
      tick();
    end
    vdp_slot = 1'b0; vdp_adr = 15'h6ABC;
    #1;
    checks++; if (ram_addr !== adr || ram_we !== exp_we || (exp_we && ram_din !== wd)) begin errors++;
      $display("FAIL issue: addr=%h we=%b din=%h want addr=%h we=%b din=%h", ram_addr, ram_we, ram_din, adr, exp_we, wd); end
    checks++; if (aux_starve !== (busy >= SMAX) || aux_ack !== 1'b0) begin errors++;
      $display("FAIL issue_flags: starve=%b ack=%b want %b/0", aux_starve, aux_ack, (busy >= SMAX)); end
    if (busy > 0) begin
      checks++; if (vdp_dbi !== ref_mem[vaddr]) begin errors++;
        $display("FAIL vdp_dbi_issue: got %h want %h", vdp_dbi, ref_mem[vaddr]); end
    end
    tick();
    checks++; if (aux_ack !== 1'b0 || ram_we !== 1'b0 || aux_busy !== 1'b1) begin errors++;
      $display("FAIL data_cycle: ack=%b we=%b busy=%b want 0/0/1", aux_ack, ram_we, aux_busy); end
    if (busy > 0) begin
      checks++; if (vdp_dbi !== ref_mem[vaddr]) begin errors++;
        $display("FAIL vdp_dbi_hold: got %h want %h", vdp_dbi, ref_mem[vaddr]); end
    end
    tick();
    aux_req = 1'b0;
    checks++; if (aux_ack !== 1'b1 || aux_rdata !== exp_rd || aux_busy !== 1'b0) begin errors++;
      $display("FAIL ack: ack=%b rdata=%h busy=%b want 1/%h/0", aux_ack, aux_rdata, aux_busy, exp_rd); end
    if (exp_we) ref_mem[adr] = wd;
    tick();
    checks++; if (aux_ack !== 1'b0 || aux_busy !== 1'b0) begin errors++;
      $display("FAIL after_ack: ack=%b busy=%b want 0/0", aux_ack, aux_busy); end
  endtask

  task automatic test_reset();
    checks++; if (aux_ack !== 1'b0 || aux_rdata !== 8'h00 || aux_busy !== 1'b0 || aux_starve !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h busy=%b starve=%b want 0/00/0/0", aux_ack, aux_rdata, aux_busy, aux_starve); end
    vdp_slot = 1'b1; vdp_we_n = 1'b0; vdp_adr = 15'h0100; vdp_dbo = 8'h77;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 15'h0100 || ram_din !== 8'h77) begin errors++;
      $display("FAIL reset_vdp_write: we=%b addr=%h din=%h want 1/0100/77", ram_we, ram_addr, ram_din); end
    tick();
    ref_mem[15'h0100] = 8'h77;
    vdp_we_n = 1'b1;
    tick();
    checks++; if (vdp_dbi !== 8'h77) begin errors++;
      $display("FAIL reset_vdp_read: got %h want 77", vdp_dbi); end
    vdp_slot = 1'b0;
    rst_n_w = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    preload(15'h1234, 8'hA5);
    run_aux(1'b0, 15'h1234, 8'h00, 0, 15'h0000);
    checks++; if (aux_rdata !== 8'hA5) begin errors++;
      $display("FAIL basic_read_hold: got %h want a5", aux_rdata); end
  endtask

  task automatic test_starve();
    run_aux(1'b0, 15'h0003, 8'h00, 4, 15'h0007);
    run_aux(1'b0, 15'h0004, 8'h00, 3, 15'h0008);
  endtask

  task automatic test_vdp_protect();
    preload(15'h0010, 8'h3C);
    preload(15'h0020, 8'h99);
    run_aux(1'b0, 15'h0020, 8'h00, 1, 15'h0010);
    checks++; if (aux_rdata !== 8'h99) begin errors++;
      $display("FAIL protect_rdata: got %h want 99", aux_rdata); end
  endtask

  task automatic test_write();
    logic [7:0] want;
    want = AUX_WE ? 8'h5A : 8'h11;
    preload(15'h7FFF, 8'h11);
    run_aux(1'b1, 15'h7FFF, 8'h5A, 0, 15'h0000);
    run_aux(1'b0, 15'h7FFF, 8'h00, 0, 15'h0000);
    checks++; if (aux_rdata !== want) begin errors++;
      $display("FAIL write_readback: got %h want %h", aux_rdata, want); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a [3];
    int acks;
    for (int k = 0; k < 3; k++) a[k] = ADDR_W'($urandom_range(0, 15));
    acks = 0;
    vdp_slot = 1'b0; vdp_we_n = 1'b1;
    aux_req = 1'b1; aux_wr = 1'b0; aux_adr = a[0];
    for (int t = 1; t <= 9; t++) begin
      tick();
      checks++; if (aux_ack !== 1'((t % 3) == 0)) begin errors++;
        $display("FAIL b2b_ack_timing: tick %0d ack=%b want %b", t, aux_ack, ((t % 3) == 0)); end
      if (aux_ack === 1'b1 && acks < 3) begin
        checks++; if (aux_rdata !== ref_mem[a[acks]]) begin errors++;
          $display("FAIL b2b_rdata: txn %0d got %h want %h", acks, aux_rdata, ref_mem[a[acks]]); end
        acks++;
        if (acks < 3) aux_adr = a[acks];
      end
    end
    aux_req = 1'b0;
    tick();
    checks++; if (acks != 3 || aux_ack !== 1'b0 || aux_busy !== 1'b0) begin errors++;
      $display("FAIL b2b_count: acks=%0d ack=%b busy=%b want 3/0/0", acks, aux_ack, aux_busy); end
  endtask

  task automatic test_reset_mid();
    aux_req = 1'b1; aux_wr = 1'b0; aux_adr = 15'h0005; vdp_slot = 1'b0;
    tick();
    aux_req = 1'b0;
    tick();
    checks++; if (aux_busy !== 1'b1) begin errors++;
      $display("FAIL mid_busy: got %b want 1", aux_busy); end
    rst_n_w = 1'b0;
    #1;
    checks++; if (aux_busy !== 1'b0 || aux_ack !== 1'b0 || aux_rdata !== 8'h00 || aux_starve !== 1'b0 || ram_we !== 1'b0) begin errors++;
      $display("FAIL mid_reset_values: busy=%b ack=%b rdata=%h starve=%b we=%b want 0/0/00/0/0", aux_busy, aux_ack, aux_rdata, aux_starve, ram_we); end
    tick();
    tick();
    rst_n_w = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (aux_ack !== 1'b0 || aux_busy !== 1'b0) begin errors++;
        $display("FAIL mid_no_ack: ack=%b busy=%b want 0/0", aux_ack, aux_busy); end
    end
    run_aux(1'b0, 15'h0006, 8'h00, 2, 15'h0009);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_aux(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 5)), ADDR_W'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst_n_w = 1'b0;
    vdp_slot = 1'b0; vdp_we_n = 1'b1; vdp_adr = '0; vdp_dbo = 8'h00;
    aux_req = 1'b0; aux_wr = 1'b0; aux_adr = '0; aux_wdata = 8'h00;
    tick();
    tick();
    test_reset();
    for (int i = 0; i < 16; i++) preload(ADDR_W'(i), 8'($urandom));
    test_basic_read();
    test_starve();
    test_vdp_protect();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
